// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the cacheline arbiter: FSM states, arbitration modes and
// the cacheline port widths shared with the cache DFP interface.
package module_types;
  localparam int CACHE_ADDR_W = 32;
  localparam int CACHE_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;
endpackage

// File: rtl/mem_req_arbiter_pick.sv
// Combinational winner select: fixed priority with starvation override, or
// round-robin search starting at start_i and wrapping to channel 0.
module arb_pick
  import module_types::*;
#(
  parameter int NUM_CH = 3,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  start_i,
  input  logic [NUM_CH-1:0] starved_i,
  input  arb_mode_t         mode_i,
  output logic [NUM_CH-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]  gnt_idx_o,
  output logic              any_o
);
  logic [NUM_CH-1:0]   cand;
  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  logic [IDX_W-1:0]    off;
  logic [IDX_W:0]      sum;

  always_comb begin
    cand = (|(req_i & starved_i)) ? (req_i & starved_i) : req_i;
    // rotate so that bit 0 is the start channel; the lowest set bit is the offset
    dbl  = {req_i, req_i} >> start_i;
    rot  = dbl[NUM_CH-1:0];
    off  = '0;
    for (int k = NUM_CH-1; k >= 0; k--)
      if (rot[k]) off = IDX_W'(k);
    sum = {1'b0, start_i} + {1'b0, off};
    if (sum >= (IDX_W+1)'(NUM_CH)) sum = sum - (IDX_W+1)'(NUM_CH);

    gnt_idx_o = '0;
    if (mode_i == ARB_RR) begin
      gnt_idx_o = sum[IDX_W-1:0];
    end else begin
      for (int k = NUM_CH-1; k >= 0; k--)
        if (cand[k]) gnt_idx_o = IDX_W'(k);
    end
    any_o    = |req_i;
    gnt_oh_o = any_o ? (NUM_CH'(1) << gnt_idx_o) : '0;
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// N-channel cacheline arbiter in front of a single DFP port; one outstanding
// transaction, registered DFP outputs, fixed-priority-with-aging or round-robin.
module mem_req_arbiter
  import module_types::*;
#(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = CACHE_ADDR_W,
  parameter int LINE_W       = CACHE_LINE_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arb_mode,
  input  logic [NUM_CH*ADDR_W-1:0]    ufp_addr,
  input  logic [NUM_CH-1:0]           ufp_read,
  input  logic [NUM_CH-1:0]           ufp_write,
  input  logic [NUM_CH*LINE_W-1:0]    ufp_wdata,
  output logic [LINE_W-1:0]           ufp_rdata,
  output logic [NUM_CH-1:0]           ufp_resp,
  output logic [ADDR_W-1:0]           dfp_addr,
  output logic                        dfp_read,
  output logic                        dfp_write,
  output logic [LINE_W-1:0]           dfp_wdata,
  input  logic [LINE_W-1:0]           dfp_rdata,
  input  logic                        dfp_resp,
  output logic [$clog2(NUM_CH)-1:0]   grant_id,
  output logic                        busy
);
  localparam int IDX_W = $clog2(NUM_CH);
  localparam int AGE_W = $clog2(STARVE_LIMIT+1);

  arb_state_t                       state_q, state_d;
  logic [IDX_W-1:0]                 rr_ptr_q, grant_q;
  logic [NUM_CH-1:0][AGE_W-1:0]     age_q;
  logic [ADDR_W-1:0]                dfp_addr_q;
  logic [LINE_W-1:0]                dfp_wdata_q, rdata_q;
  logic                             dfp_read_q, dfp_write_q;
  logic [NUM_CH-1:0]                ufp_resp_q;

  logic [NUM_CH-1:0]                req, starved, win_oh;
  logic [IDX_W-1:0]                 win_idx;
  logic                             win_any, arb_go;
  logic [NUM_CH-1:0][ADDR_W-1:0]    addr_arr;
  logic [NUM_CH-1:0][LINE_W-1:0]    wdata_arr;

  assign req       = ufp_read | ufp_write;
  assign addr_arr  = ufp_addr;
  assign wdata_arr = ufp_wdata;
  assign arb_go    = (state_q == IDLE) && win_any;

  always_comb
    for (int c = 0; c < NUM_CH; c++)
      starved[c] = (age_q[c] == AGE_W'(STARVE_LIMIT));

  arb_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req_i     (req),
    .start_i   (rr_ptr_q),
    .starved_i (starved),
    .mode_i    (arb_mode_t'(arb_mode)),
    .gnt_oh_o  (win_oh),
    .gnt_idx_o (win_idx),
    .any_o     (win_any)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_any)  state_d = GRANT;
      GRANT:   if (dfp_resp) state_d = RESP;
      RESP:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      age_q       <= '0;
      dfp_addr_q  <= '0;
      dfp_wdata_q <= '0;
      dfp_read_q  <= 1'b0;
      dfp_write_q <= 1'b0;
      rdata_q     <= '0;
      ufp_resp_q  <= '0;
    end else begin
      state_q    <= state_d;
      ufp_resp_q <= '0;
      if (arb_go) begin
        grant_q     <= win_idx;
        dfp_addr_q  <= addr_arr[win_idx];
        dfp_wdata_q <= wdata_arr[win_idx];
        dfp_read_q  <= ufp_read[win_idx];
        dfp_write_q <= ufp_write[win_idx];
        rr_ptr_q    <= (win_idx == IDX_W'(NUM_CH-1)) ? '0 : win_idx + 1'b1;
      end
      if (state_q == GRANT && dfp_resp) begin
        dfp_read_q  <= 1'b0;
        dfp_write_q <= 1'b0;
        rdata_q     <= dfp_rdata;
        ufp_resp_q  <= NUM_CH'(1) << grant_q;
      end
      // ages only move on an actual IDLE arbitration; idle channels forget their wait
      for (int c = 0; c < NUM_CH; c++) begin
        if (!req[c])
          age_q[c] <= '0;
        else if (arb_go)
          age_q[c] <= win_oh[c] ? '0 : (starved[c] ? age_q[c] : age_q[c] + 1'b1);
      end
    end
  end

  assign dfp_addr  = dfp_addr_q;
  assign dfp_wdata = dfp_wdata_q;
  assign dfp_read  = dfp_read_q;
  assign dfp_write = dfp_write_q;
  assign ufp_rdata = rdata_q;
  assign ufp_resp  = ufp_resp_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE);

  a_no_rw: assert property (@(posedge clk) disable iff (rst) !(|(ufp_read & ufp_write)));
  a_resp_in_grant: assert property (@(posedge clk) disable iff (rst) dfp_resp |-> state_q == GRANT);
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level reference model.
module tb_mem_req_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int SL = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            arb_mode;
  logic [N*AW-1:0] ufp_addr;
  logic [N-1:0]    ufp_read, ufp_write;
  logic [N*LW-1:0] ufp_wdata;
  logic [LW-1:0]   ufp_rdata;
  logic [N-1:0]    ufp_resp;
  logic [AW-1:0]   dfp_addr;
  logic            dfp_read, dfp_write;
  logic [LW-1:0]   dfp_wdata;
  logic [LW-1:0]   dfp_rdata = '0;
  logic            dfp_resp = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;

  mem_req_arbiter #(.NUM_CH(N), .ADDR_W(AW), .LINE_W(LW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .arb_mode(arb_mode),
    .ufp_addr(ufp_addr), .ufp_read(ufp_read), .ufp_write(ufp_write), .ufp_wdata(ufp_wdata),
    .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write), .dfp_wdata(dfp_wdata),
    .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired", nm);
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- reference model (one transaction in flight at a time)
  int            m_ph;     // 0 free, 1 waiting on memory, 2 completing
  int            m_owner, m_ptr, exp_gid;
  int            m_age[N];
  logic          m_rd, exp_read, exp_write;
  logic [AW-1:0] exp_addr;
  logic [LW-1:0] exp_wdata, exp_rdata;
  logic [N-1:0]  exp_resp;

  function automatic int pick(input logic [N-1:0] req);
    int w = -1;
    if (arb_mode) begin
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(m_ptr+k)%N]) w = (m_ptr+k)%N;
      return w;
    end
    for (int k = 0; k < N; k++) if (w < 0 && req[k] && m_age[k] == SL) w = k;
    for (int k = 0; k < N; k++) if (w < 0 && req[k]) w = k;
    return w;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = 0; m_owner = 0; m_ptr = 0; exp_gid = 0; m_rd = 0;
      foreach (m_age[c]) m_age[c] = 0;
      exp_read = 0; exp_write = 0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0; exp_resp = '0;
    end else begin
      logic [N-1:0] req;
      int w;
      req = ufp_read | ufp_write;
      if (m_ph == 2) begin
        exp_resp = '0;
        m_ph = 0;
      end else if (m_ph == 1) begin
        if (dfp_resp) begin
          exp_read = 0; exp_write = 0;
          exp_rdata = dfp_rdata;
          exp_resp = N'(1) << m_owner;
          m_ph = 2;
        end
      end else if (req != 0) begin
        w = pick(req);
        for (int c = 0; c < N; c++)
          if (req[c]) m_age[c] = (c == w) ? 0 : ((m_age[c] < SL) ? m_age[c] + 1 : SL);
        m_owner = w; exp_gid = w; m_ptr = (w + 1) % N;
        exp_read = ufp_read[w]; exp_write = ufp_write[w]; m_rd = ufp_read[w];
        exp_addr = ufp_addr[w*AW +: AW];
        exp_wdata = ufp_wdata[w*LW +: LW];
        m_ph = 1;
      end
      for (int c = 0; c < N; c++) if (!req[c]) m_age[c] = 0;
    end
  end

  always @(negedge clk) begin
    check("dfp_read", dfp_read, exp_read);
    check("dfp_write", dfp_write, exp_write);
    check("busy", busy, m_ph != 0);
    check("ufp_resp", ufp_resp, exp_resp);
    if (m_ph != 0) begin
      check("dfp_addr", dfp_addr, exp_addr);
      check("dfp_wdata", dfp_wdata, exp_wdata);
      check("grant_id", grant_id, exp_gid);
    end
    if (exp_resp != 0 && m_rd) check("ufp_rdata", ufp_rdata, exp_rdata);
  end

  // ---------------- memory responder
  int            mem_lat = -1, mem_wait = -1;
  logic          mem_fix = 1'b0;
  logic [LW-1:0] mem_line = '0;

  always @(negedge clk) begin
    dfp_resp = 1'b0;
    if (dfp_read || dfp_write) begin
      if (mem_wait < 0) mem_wait = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 4));
      if (mem_wait == 0) begin
        dfp_resp  = 1'b1;
        dfp_rdata = mem_fix ? mem_line : rand_line();
        mem_wait  = -1;
      end else mem_wait--;
    end else mem_wait = -1;
  end

  // ---------------- grant log (one entry per transaction start)
  typedef struct { int id; logic wr; logic [AW-1:0] addr; logic [LW-1:0] wdata; } gnt_t;
  gnt_t glog[$];
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (busy && !busy_prev) begin
      gnt_t g;
      g.id = int'(grant_id); g.wr = dfp_write; g.addr = dfp_addr; g.wdata = dfp_wdata;
      glog.push_back(g);
    end
    busy_prev = busy;
  end

  // ---------------- stimulus helpers
  task automatic set_req(input int c, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
    ufp_read[c] = !wr; ufp_write[c] = wr;
    ufp_addr[c*AW +: AW] = a; ufp_wdata[c*LW +: LW] = d;
  endtask

  task automatic drop(input int c);
    ufp_read[c] = 1'b0; ufp_write[c] = 1'b0;
  endtask

  task automatic run(input int n, input bit autodrop);
    repeat (n) begin
      @(negedge clk);
      if (autodrop) for (int c = 0; c < N; c++) if (ufp_resp[c]) drop(c);
    end
  endtask

  task automatic quiet();
    ufp_read = '0; ufp_write = '0;
    run(4, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
  endtask

  task automatic rand_step();
    for (int c = 0; c < N; c++) begin
      if (ufp_read[c] || ufp_write[c]) begin
        if (ufp_resp[c]) begin
          if ($urandom_range(0, 1) == 1) set_req(c, $urandom_range(0, 1) == 1, $urandom, rand_line());
          else drop(c);
        end else if (!(m_ph != 0 && m_owner == c) && $urandom_range(0, 15) == 0) drop(c);
      end else if ($urandom_range(0, 3) == 0) begin
        set_req(c, $urandom_range(0, 1) == 1, $urandom, rand_line());
      end
    end
    if ($urandom_range(0, 63) == 0) arb_mode = ~arb_mode;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int rr_exp[6] = '{0, 1, 2, 0, 1, 2};
  int st_exp[3] = '{0, 0, 2};
  logic [LW-1:0] w1;

  initial begin
    rst = 1'b1; arb_mode = 1'b0;
    ufp_addr = '0; ufp_read = '0; ufp_write = '0; ufp_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_dfp_read", dfp_read, 0);
    check("rst_busy", busy, 0);
    check("rst_ufp_resp", ufp_resp, 0);
    check("rst_dfp_addr", dfp_addr, 0);
    check("rst_grant_id", grant_id, 0);
    rst = 1'b0;
    @(negedge clk);

    // single read on ch1
    mem_lat = 5; mem_fix = 1'b1; mem_line = {8{32'hA5A5_0001}};
    set_req(1, 1'b0, 32'h1000, '0);
    @(negedge clk);
    check("single_dfp_read_latency", dfp_read, 1);
    check("single_dfp_addr", dfp_addr, 32'h1000);
    check("single_grant_id", grant_id, 1);
    begin
      int i;
      for (i = 0; i < 50 && ufp_resp == 0; i++) @(negedge clk);
      if (ufp_resp == 0) fail_now("single_resp_wait");
    end
    check("single_ufp_resp", ufp_resp, 3'b010);
    check("single_ufp_rdata", ufp_rdata, {8{32'hA5A5_0001}});
    drop(1);
    @(negedge clk);
    check("single_resp_pulse_end", ufp_resp, 0);
    quiet();

    // round-robin contention from a fresh pointer
    pulse_reset();
    mem_fix = 1'b0; mem_lat = 1; arb_mode = 1'b1; glog.delete();
    set_req(0, 1'b0, 32'h100, '0); set_req(1, 1'b0, 32'h200, '0); set_req(2, 1'b0, 32'h300, '0);
    run(45, 0);
    if (glog.size() < 6) fail_now("rr_grant_count");
    else for (int i = 0; i < 6; i++) check($sformatf("rr_order_%0d", i), glog[i].id, rr_exp[i]);
    quiet();

    // fixed priority with starvation promotion
    arb_mode = 1'b0; glog.delete();
    set_req(0, 1'b0, 32'h400, '0); set_req(2, 1'b0, 32'h500, '0);
    run(30, 0);
    if (glog.size() < 3) fail_now("starve_grant_count");
    else for (int i = 0; i < 3; i++) check($sformatf("starve_order_%0d", i), glog[i].id, st_exp[i]);
    quiet();

    // write on ch1 while ch0 read pending
    glog.delete(); w1 = {8{32'hDEAD_0002}};
    set_req(0, 1'b0, 32'h3000, '0); set_req(1, 1'b1, 32'h2000, w1);
    run(30, 1);
    check("wr_rd_grant_count", glog.size(), 2);
    if (glog.size() >= 2) begin
      check("wr_rd_first_id", glog[0].id, 0);
      check("wr_rd_first_op", glog[0].wr, 0);
      check("wr_rd_first_addr", glog[0].addr, 32'h3000);
      check("wr_rd_second_id", glog[1].id, 1);
      check("wr_rd_second_op", glog[1].wr, 1);
      check("wr_rd_second_addr", glog[1].addr, 32'h2000);
      check("wr_rd_second_wdata", glog[1].wdata, w1);
    end
    quiet();

    // withdrawal while ch0 owns the port
    glog.delete(); mem_lat = 4;
    set_req(0, 1'b0, 32'h4000, '0);
    @(negedge clk);
    set_req(2, 1'b0, 32'h5000, '0);
    @(negedge clk);
    drop(2);
    run(20, 1);
    check("withdraw_grant_count", glog.size(), 1);
    if (glog.size() >= 1) check("withdraw_owner", glog[0].id, 0);
    quiet();

    // async reset in GRANT
    arb_mode = 1'b1; mem_lat = 5;
    set_req(1, 1'b0, 32'h6000, '0);
    @(negedge clk);
    check("arst_pre_dfp_read", dfp_read, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_dfp_read", dfp_read, 0);
    check("arst_busy", busy, 0);
    drop(1);
    @(negedge clk);
    rst = 1'b0;
    glog.delete();
    set_req(0, 1'b0, 32'h700, '0); set_req(1, 1'b0, 32'h800, '0); set_req(2, 1'b0, 32'h900, '0);
    run(12, 1);
    if (glog.size() < 1) fail_now("arst_regrant");
    else check("arst_rr_ptr_zero", glog[0].id, 0);
    quiet();

    // randomized traffic
    mem_lat = -1;
    repeat (3000) begin
      @(negedge clk);
      rand_step();
    end
    quiet();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
